ghazi_ram_arbiter: RTL and testbench

- Shares one single-port DFFRAM macro between two requesters: the management SoC Wishbone slave port (requester 0) and the Ghazi core data port (requester 1, req/gnt/rvalid protocol).
- Sits inside ghazi_top, between the user-area Wishbone slave and the core data bus on one side and the DFFRAM instance on the other.
- Arbitrates round-robin, issues one RAM access per cycle, and returns read data on the cycle after issue.

---
 rtl/ghazi_arb_pkg.sv | 24 ++
 rtl/ghazi_rr_arb2.sv | 38 +++
 rtl/ghazi_ram_arbiter.sv | 107 ++++++++++
 tb/tb_ghazi_ram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghazi_arb_pkg.sv
// ghazi_arb_pkg: shared types and constants for the Ghazi RAM arbiter.
// Rev 1.0
`default_nettype none

package ghazi_arb_pkg;

   // Requester indices into the req/gnt vectors
   localparam int REQ_WB   = 0;
   localparam int REQ_CORE = 1;

   localparam int          ARB_ADDR_W  = 8;
   localparam logic [31:0] WB_BASE_DEF = 32'h3000_0000;
   localparam logic [31:0] WB_MASK_DEF = 32'h0000_03FF;

   typedef struct packed {
      logic                  we;
      logic [3:0]            be;
      logic [ARB_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
   } arb_req_t;

endpackage

`default_nettype wire

// File: rtl/ghazi_rr_arb2.sv
// ghazi_rr_arb2: two-way round-robin arbiter with one-hot combinational grant.
// Rev 1.0
`default_nettype none

module ghazi_rr_arb2
   import ghazi_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // Index of the requester granted most recently; starts at the core so WB wins the first tie.
   logic rr_last;

   always_comb begin
      gnt = 2'b00;
      if (req[REQ_WB] && (!req[REQ_CORE] || rr_last == 1'b1)) begin
         gnt[REQ_WB] = 1'b1;
      end else if (req[REQ_CORE]) begin
         gnt[REQ_CORE] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_last <= 1'b1;
      end else if (gnt[REQ_WB]) begin
         rr_last <= 1'b0;
      end else if (gnt[REQ_CORE]) begin
         rr_last <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ghazi_ram_arbiter.sv
// ghazi_ram_arbiter: shares one single-port DFFRAM between the Wishbone slave and the core data port.
// Rev 1.0
`default_nettype none

module ghazi_ram_arbiter
   import ghazi_arb_pkg::*;
#(
   parameter int          ADDR_W  = ARB_ADDR_W,
   parameter logic [31:0] WB_BASE = WB_BASE_DEF,
   parameter logic [31:0] WB_MASK = WB_MASK_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              core_req_i,
   output logic              core_gnt_o,
   input  logic              core_we_i,
   input  logic [3:0]        core_be_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [31:0]       core_wdata_i,
   output logic              core_rvalid_o,
   output logic [31:0]       core_rdata_o,
   output logic              ram_en_o,
   output logic [3:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_di_o,
   input  logic [31:0]       ram_do_i
);

   logic              wb_pend;
   logic              wb_rd_hit;
   logic              core_pend;
   logic              wb_hit;
   logic              granted;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] hold_addr;
   logic [31:0]       hold_wdata;
   arb_req_t          wb_bus;
   arb_req_t          core_bus;
   arb_req_t          sel_bus;

   assign wb_hit        = ((wbs_adr_i & ~WB_MASK) == WB_BASE);
   assign req[REQ_WB]   = wbs_cyc_i & wbs_stb_i & ~wb_pend;
   assign req[REQ_CORE] = core_req_i;

   ghazi_rr_arb2 u_rr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (req),
      .gnt    (gnt)
   );

   always_comb begin
      wb_bus.we      = wbs_we_i;
      wb_bus.be      = wbs_sel_i;
      wb_bus.addr    = wbs_adr_i[ADDR_W+1:2];
      wb_bus.wdata   = wbs_dat_i;
      core_bus.we    = core_we_i;
      core_bus.be    = core_be_i;
      core_bus.addr  = core_addr_i;
      core_bus.wdata = core_wdata_i;
      sel_bus        = gnt[REQ_CORE] ? core_bus : wb_bus;
   end

   assign granted    = |gnt;
   assign core_gnt_o = gnt[REQ_CORE];
   // A Wishbone window miss is granted (so it gets its ack) but never reaches the RAM.
   assign ram_en_o   = (gnt[REQ_WB] & wb_hit) | gnt[REQ_CORE];
   assign ram_we_o   = (ram_en_o && sel_bus.we) ? sel_bus.be : 4'b0000;
   assign ram_addr_o = granted ? sel_bus.addr  : hold_addr;
   assign ram_di_o   = granted ? sel_bus.wdata : hold_wdata;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_pend    <= 1'b0;
         wb_rd_hit  <= 1'b0;
         core_pend  <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
      end else begin
         wb_pend   <= gnt[REQ_WB];
         wb_rd_hit <= gnt[REQ_WB] & wb_hit & ~wbs_we_i;
         core_pend <= gnt[REQ_CORE];
         if (granted) begin
            hold_addr  <= sel_bus.addr;
            hold_wdata <= sel_bus.wdata;
         end
      end
   end

   // Response data comes straight from the RAM in the cycle after issue, gated to zero otherwise.
   assign wbs_ack_o     = wb_pend;
   assign wbs_dat_o     = wb_rd_hit ? ram_do_i : 32'h0;
   assign core_rvalid_o = core_pend;
   assign core_rdata_o  = core_pend ? ram_do_i : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_ghazi_ram_arbiter.sv
// tb_ghazi_ram_arbiter: directed plus randomized check of the arbiter against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_ghazi_ram_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        core_req_i, core_gnt_o, core_we_i;
   logic [3:0]  core_be_i;
   logic [7:0]  core_addr_i;
   logic [31:0] core_wdata_i;
   logic        core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic        ram_en_o;
   logic [3:0]  ram_we_o;
   logic [7:0]  ram_addr_o;
   logic [31:0] ram_di_o;
   logic [31:0] ram_do_i;

   always #5 clk_i = ~clk_i;

   ghazi_ram_arbiter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
      .core_be_i(core_be_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_di_o(ram_di_o), .ram_do_i(ram_do_i)
   );

   // Behavioural DFFRAM: synchronous read, byte-masked write.
   logic [31:0] ram_env [256];
   logic [31:0] env_w;
   always @(posedge clk_i) begin
      if (ram_en_o) begin
         ram_do_i <= ram_env[ram_addr_o];
         env_w = ram_env[ram_addr_o];
         for (int b = 0; b < 4; b++)
            if (ram_we_o[b]) env_w[8*b +: 8] = ram_di_o[8*b +: 8];
         ram_env[ram_addr_o] = env_w;
      end
   end

   // Reference model state
   logic [31:0] mem_m [256];
   bit          m_last_core, m_wb_pend, m_core_pend, m_core_rd;
   logic [31:0] m_wb_dat, m_core_dat, m_hold_di;
   logic [7:0]  m_hold_addr;
   bit          seen_ack, seen_core_gnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      chk(name, {31'b0, got}, {31'b0, exp});
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_last_core = 1'b1;
      m_wb_pend   = 1'b0;
      m_core_pend = 1'b0;
      m_core_rd   = 1'b0;
      m_wb_dat    = 32'h0;
      m_core_dat  = 32'h0;
      m_hold_di   = 32'h0;
      m_hold_addr = 8'h0;
   endtask

   task automatic set_idle();
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
      wbs_adr_i = 0; wbs_dat_i = 0;
      core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;
   endtask

   // Compare every output against the model for the current cycle, then advance the model.
   task automatic step();
      bit         wb_req, hit, win_wb, win_core;
      logic [7:0] wa;
      logic [3:0] exp_we;
      #1;
      wb_req   = wbs_cyc_i && wbs_stb_i && !m_wb_pend;
      hit      = (wbs_adr_i >= 32'h3000_0000) && (wbs_adr_i < 32'h3000_0400);
      wa       = 8'((wbs_adr_i / 4) % 256);
      win_wb   = wb_req && (!core_req_i || m_last_core);
      win_core = core_req_i && !win_wb;

      chk1("core_gnt", core_gnt_o, win_core);
      chk1("ram_en", ram_en_o, (win_wb && hit) || win_core);
      if (win_core) begin
         exp_we = core_we_i ? core_be_i : 4'h0;
         chk("ram_we", {28'b0, ram_we_o}, {28'b0, exp_we});
         chk("ram_addr", {24'b0, ram_addr_o}, {24'b0, core_addr_i});
         chk("ram_di", ram_di_o, core_wdata_i);
      end else if (win_wb) begin
         exp_we = wbs_we_i ? wbs_sel_i : 4'h0;
         if (hit) chk("ram_we", {28'b0, ram_we_o}, {28'b0, exp_we});
         chk("ram_addr", {24'b0, ram_addr_o}, {24'b0, wa});
         chk("ram_di", ram_di_o, wbs_dat_i);
      end else begin
         chk("ram_we_idle", {28'b0, ram_we_o}, 32'h0);
         chk("ram_addr_hold", {24'b0, ram_addr_o}, {24'b0, m_hold_addr});
         chk("ram_di_hold", ram_di_o, m_hold_di);
      end
      chk1("wbs_ack", wbs_ack_o, m_wb_pend);
      chk("wbs_dat", wbs_dat_o, m_wb_dat);
      chk1("core_rvalid", core_rvalid_o, m_core_pend);
      if (m_core_pend && m_core_rd) chk("core_rdata", core_rdata_o, m_core_dat);
      else if (!m_core_pend)        chk("core_rdata_idle", core_rdata_o, 32'h0);

      seen_ack      = m_wb_pend;
      seen_core_gnt = win_core;
      m_wb_pend     = win_wb;
      m_wb_dat      = 32'h0;
      if (win_wb) begin
         if (hit && !wbs_we_i) m_wb_dat = mem_m[wa];
         if (hit && wbs_we_i)  mem_m[wa] = merge(mem_m[wa], wbs_dat_i, wbs_sel_i);
         m_last_core = 1'b0;
         m_hold_addr = wa;
         m_hold_di   = wbs_dat_i;
      end
      m_core_pend = win_core;
      if (win_core) begin
         m_core_rd  = !core_we_i;
         m_core_dat = mem_m[core_addr_i];
         if (core_we_i) mem_m[core_addr_i] = merge(mem_m[core_addr_i], core_wdata_i, core_be_i);
         m_last_core = 1'b1;
         m_hold_addr = core_addr_i;
         m_hold_di   = core_wdata_i;
      end
   endtask

   // One Wishbone access: issue cycle, ack cycle (strobe still high), then idle.
   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output logic iss_en, output logic [7:0] iss_addr,
                            output logic [3:0] iss_we, output logic ack, output logic [31:0] rd,
                            output logic ack_after);
      @(negedge clk_i);
      set_idle();
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = 4'hF;
      wbs_adr_i = adr; wbs_dat_i = dat;
      step();
      iss_en = ram_en_o; iss_addr = ram_addr_o; iss_we = ram_we_o;
      @(negedge clk_i);
      step();
      ack = wbs_ack_o; rd = wbs_dat_o;
      @(negedge clk_i);
      set_idle();
      step();
      ack_after = wbs_ack_o;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        en, ack, ack2, prev_g, wb_act, core_act, wb_done, core_done;
      logic [7:0]  a;
      logic [3:0]  w;
      logic [31:0] rd;
      int          n_core, n_wb;

      for (int i = 0; i < 256; i++) begin
         ram_env[i] = 32'hA5A5_0000 | i;
         mem_m[i]   = 32'hA5A5_0000 | i;
      end
      set_idle();
      model_reset();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      chk1("rst_ack", wbs_ack_o, 1'b0);
      chk("rst_wbdat", wbs_dat_o, 32'h0);
      chk1("rst_rvalid", core_rvalid_o, 1'b0);
      chk("rst_rdata", core_rdata_o, 32'h0);
      chk1("rst_en", ram_en_o, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      // Single write then read-back
      wb_access(1'b1, 32'h3000_0010, 32'hDEADBEEF, en, a, w, ack, rd, ack2);
      chk1("wr_en", en, 1'b1);
      chk("wr_addr", {24'b0, a}, 32'd4);
      chk("wr_we", {28'b0, w}, 32'hF);
      chk1("wr_ack", ack, 1'b1);
      chk1("wr_ack_once", ack2, 1'b0);
      wb_access(1'b0, 32'h3000_0010, 32'h0, en, a, w, ack, rd, ack2);
      chk("rd_back", rd, 32'hDEADBEEF);

      // Core read burst, addresses 0..3
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         set_idle();
         core_req_i = 1; core_addr_i = 8'(i); core_wdata_i = $urandom;
         step();
         chk1("burst_gnt", core_gnt_o, 1'b1);
         chk1("burst_rvalid", core_rvalid_o, i > 0);
         if (i > 0) chk("burst_rdata", core_rdata_o, 32'hA5A5_0000 + 32'(i - 1));
      end
      @(negedge clk_i);
      set_idle();
      step();
      chk1("burst_rvalid_last", core_rvalid_o, 1'b1);
      chk("burst_rdata_last", core_rdata_o, 32'hA5A5_0003);

      // Out-of-window read and write
      wb_access(1'b0, 32'h3000_0400, 32'h0, en, a, w, ack, rd, ack2);
      chk1("miss_rd_en", en, 1'b0);
      chk1("miss_rd_ack", ack, 1'b1);
      chk("miss_rd_dat", rd, 32'h0);
      wb_access(1'b1, 32'h3000_0400, 32'h1234_5678, en, a, w, ack, rd, ack2);
      chk1("miss_wr_en", en, 1'b0);
      wb_access(1'b0, 32'h3000_0000, 32'h0, en, a, w, ack, rd, ack2);
      chk("miss_wr_untouched", rd, 32'hA5A5_0000);

      // Core byte write onto 0x11223344
      wb_access(1'b1, 32'h3000_0014, 32'h1122_3344, en, a, w, ack, rd, ack2);
      @(negedge clk_i);
      set_idle();
      core_req_i = 1; core_we_i = 1; core_be_i = 4'b0010; core_addr_i = 8'd5;
      core_wdata_i = 32'h0000_AB00;
      step();
      chk("byte_we", {28'b0, ram_we_o}, 32'h2);
      @(negedge clk_i);
      set_idle();
      step();
      wb_access(1'b0, 32'h3000_0014, 32'h0, en, a, w, ack, rd, ack2);
      chk("byte_merge", rd, 32'h1122_AB44);

      // Both requesting continuously for 6 cycles
      @(negedge clk_i);
      set_idle();
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0020;
      core_req_i = 1; core_addr_i = 8'd7;
      n_core = 0; n_wb = 0; prev_g = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk_i);
         step();
         if (k > 0) chk1("contention_alt", core_gnt_o, !prev_g);
         prev_g = core_gnt_o;
         if (core_gnt_o) n_core++;
         else if (ram_en_o) n_wb++;
      end
      chk(n_core == 3 ? "contention_core" : "contention_core_cnt", 32'(n_core), 32'd3);
      chk("contention_wb", 32'(n_wb), 32'd3);
      repeat (2) begin
         @(negedge clk_i);
         set_idle();
         step();
      end

      // Reset in the cycle after a Wishbone read issue
      @(negedge clk_i);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0030;
      step();
      chk1("mid_issue_en", ram_en_o, 1'b1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      set_idle();
      model_reset();
      #1;
      chk1("mid_rst_ack", wbs_ack_o, 1'b0);
      chk("mid_rst_wbdat", wbs_dat_o, 32'h0);
      chk1("mid_rst_rvalid", core_rvalid_o, 1'b0);
      chk("mid_rst_rdata", core_rdata_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      chk1("post_rst_no_ack", wbs_ack_o, 1'b0);
      @(negedge clk_i);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040;
      core_req_i = 1; core_addr_i = 8'd9;
      step();
      chk1("post_rst_tie_core", core_gnt_o, 1'b0);
      chk1("post_rst_tie_en", ram_en_o, 1'b1);
      chk("post_rst_tie_addr", {24'b0, ram_addr_o}, 32'h10);
      @(negedge clk_i);
      step();
      chk1("post_rst_core_next", core_gnt_o, 1'b1);
      @(negedge clk_i);
      set_idle();
      step();

      // Randomized traffic
      wb_act = 0; core_act = 0; wb_done = 0; core_done = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_i);
         if (wb_done) begin
            wb_act = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
         end
         if (core_done) begin
            core_act = 0; core_req_i = 0;
         end
         if (!wb_act && $urandom_range(0, 2) != 0) begin
            wb_act = 1; wbs_cyc_i = 1; wbs_stb_i = 1;
            wbs_we_i  = 1'($urandom_range(0, 1));
            wbs_sel_i = 4'($urandom_range(0, 15));
            wbs_dat_i = $urandom;
            if ($urandom_range(0, 9) == 0) wbs_adr_i = $urandom;
            else wbs_adr_i = 32'h3000_0000 | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
         end else if (wb_act && m_wb_pend && $urandom_range(0, 3) == 0) begin
            wbs_cyc_i = 0; wbs_stb_i = 0;
         end
         if (!core_act && $urandom_range(0, 2) != 0) begin
            core_act = 1; core_req_i = 1;
            core_we_i    = 1'($urandom_range(0, 1));
            core_be_i    = 4'($urandom_range(0, 15));
            core_addr_i  = 8'($urandom_range(0, 255));
            core_wdata_i = $urandom;
         end
         step();
         wb_done   = seen_ack;
         core_done = seen_core_gnt;
      end
      repeat (3) begin
         @(negedge clk_i);
         set_idle();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
